// File: rtl/banner_scroller.sv
// Scrolling banner renderer: fetches bitmap rows from an external ROM, cuts a
// circular window at the current column offset and streams rows over valid/ready.
module banner_scroller #(
  parameter int ROWS      = 15,
  parameter int COLS      = 71,
  parameter int WIN       = 32,
  parameter int FRAME_DIV = 4,
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int OW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            frame_start,
  input  logic            scroll_en,
  input  logic            dir,
  output logic [AW-1:0]   rom_addr,
  input  logic [COLS-1:0] rom_data,
  output logic [WIN-1:0]  row_data,
  output logic [AW-1:0]   row_idx,
  output logic            row_valid,
  input  logic            row_ready,
  output logic            frame_done,
  output logic            busy,
  output logic [OW-1:0]   offset
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, OUT, DONE} state_t;

  state_t         state;
  logic [AW-1:0]  row_cnt;
  logic [FW-1:0]  frame_cnt;
  logic [COLS-1:0] rotated;

  // Rotating the ROM word left by offset puts column 'offset' at the MSB, so
  // the window is simply the top WIN bits; wrap past the last column is free.
  always_comb begin
    rotated = (rom_data << offset) | (rom_data >> (COLS - int'(offset)));
  end

  assign busy = (state != IDLE);

  // NOTE: every register here is updated with <= so that all of them see the
  // values from before the clock edge, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      row_cnt    <= '0;
      frame_cnt  <= '0;
      offset     <= '0;
      rom_addr   <= '0;
      row_data   <= '0;
      row_idx    <= '0;
      row_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            row_cnt  <= '0;
            rom_addr <= '0;
            state    <= FETCH;
          end
        end
        FETCH: begin
          state <= WAIT;
        end
        WAIT: begin
          row_data  <= WIN'(rotated >> (COLS - WIN));
          row_idx   <= row_cnt;
          row_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (row_ready) begin
            row_valid <= 1'b0;
            if (row_cnt == AW'(ROWS - 1)) begin
              rom_addr   <= '0;
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              row_cnt  <= row_cnt + 1'b1;
              rom_addr <= row_cnt + 1'b1;
              state    <= FETCH;
            end
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          state      <= IDLE;
          // Offset only moves between frames, so a frame never tears.
          if (!scroll_en) begin
            frame_cnt <= '0;
          end else if (frame_cnt == FW'(FRAME_DIV - 1)) begin
            frame_cnt <= '0;
            if (dir)
              offset <= (offset == '0) ? OW'(COLS - 1) : offset - 1'b1;
            else
              offset <= (offset == OW'(COLS - 1)) ? '0 : offset + 1'b1;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_banner_scroller.sv
// Self-checking bench for banner_scroller: directed scenarios plus randomized
// backpressure and scroll settings, checked against a column-level model.
module tb_banner_scroller;

  localparam int ROWS      = 15;
  localparam int COLS      = 71;
  localparam int WIN       = 32;
  localparam int FRAME_DIV = 4;
  localparam int AW = $clog2(ROWS);
  localparam int OW = $clog2(COLS);

  logic            clk;
  logic            rst_n;
  logic            frame_start;
  logic            scroll_en;
  logic            dir;
  logic [AW-1:0]   rom_addr;
  logic [COLS-1:0] rom_data;
  logic [WIN-1:0]  row_data;
  logic [AW-1:0]   row_idx;
  logic            row_valid;
  logic            row_ready;
  logic            frame_done;
  logic            busy;
  logic [OW-1:0]   offset;

  int checks   = 0;
  int failures = 0;

  int off_m = 0;
  int fc_m  = 0;
  logic [WIN-1:0] got [ROWS];

  banner_scroller #(
    .ROWS(ROWS), .COLS(COLS), .WIN(WIN), .FRAME_DIV(FRAME_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .scroll_en(scroll_en),
    .dir(dir), .rom_addr(rom_addr), .rom_data(rom_data), .row_data(row_data),
    .row_idx(row_idx), .row_valid(row_valid), .row_ready(row_ready),
    .frame_done(frame_done), .busy(busy), .offset(offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: row r lights only column r.
  always @(posedge clk) begin
    for (int c = 0; c < COLS; c++)
      rom_data[COLS-1-c] <= (c == int'(rom_addr));
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Visible position i shows column (off+i) mod COLS; lit only where that column is row r.
  function automatic logic [WIN-1:0] model_window(input int off, input int r);
    logic [WIN-1:0] w;
    w = '0;
    for (int i = 0; i < WIN; i++)
      if ((off + i) % COLS == r) w[WIN-1-i] = 1'b1;
    return w;
  endfunction

  function automatic void model_frame_end(input bit en, input bit d);
    if (!en) begin
      fc_m = 0;
    end else if (fc_m == FRAME_DIV - 1) begin
      fc_m  = 0;
      off_m = d ? (off_m + COLS - 1) % COLS : (off_m + 1) % COLS;
    end else begin
      fc_m = fc_m + 1;
    end
  endfunction

  // mode 0: ready held high, 1: random ready, 2: stall row 3 for 10 cycles
  task automatic run_frame(input int mode, input bit poke);
    int n;
    int r;
    int stall;
    bit seen_valid;
    @(negedge clk);
    frame_start = 1'b1;
    row_ready   = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    n = 0; r = 0; stall = 0; seen_valid = 0;
    check("busy_start", busy, 1);
    while (!frame_done && n < 3000) begin
      frame_start = 1'b0;
      if (row_valid) begin
        if (!seen_valid && mode == 0) check("first_valid_latency", n, 2);
        seen_valid = 1;
        check("row_data", row_data, model_window(off_m, r));
        check("row_idx", row_idx, r);
        check("offset_hold", offset, off_m);
        case (mode)
          0: row_ready = 1'b1;
          1: row_ready = 1'($urandom_range(0, 1));
          default: begin
            if (r == 3 && stall < 10) begin
              row_ready = 1'b0;
              stall++;
            end else begin
              row_ready = 1'b1;
            end
          end
        endcase
        frame_start = poke && (stall == 5) && (r == 3);
        if (row_ready) begin
          got[r] = row_data;
          r++;
        end
      end
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("frame_timeout", frame_done, 1);
    check("rows_done", r, ROWS);
    if (mode == 0) check("done_latency", n, 3 * ROWS);
    if (mode == 2) check("stall_cycles", stall, 10);
    check("done_rom_addr", rom_addr, 0);
    check("done_offset", offset, off_m);
    check("done_busy", busy, 1);
    model_frame_end(scroll_en, dir);
    row_ready = 1'b1;
    @(negedge clk);
    check("done_pulse_width", frame_done, 0);
    check("idle_busy", busy, 0);
    check("idle_rom_addr", rom_addr, 0);
    check("offset_next", offset, off_m);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; frame_start = 1'b0; scroll_en = 1'b0; dir = 1'b0; row_ready = 1'b1;
    #12;
    check("rst_busy", busy, 0);
    check("rst_valid", row_valid, 0);
    check("rst_offset", offset, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_row_data", row_data, 0);
    check("rst_frame_done", frame_done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain frame at offset 0
    run_frame(0, 0);
    check("f0_row0", got[0], 32'h8000_0000);
    check("f0_row1", got[1], 32'h4000_0000);
    check("f0_row14", got[14], 32'h0002_0000);

    // Left scroll: offset advances once every FRAME_DIV frames
    scroll_en = 1'b1; dir = 1'b0;
    for (int k = 0; k < FRAME_DIV; k++) begin
      check("left_offset_pre", offset, 0);
      run_frame(0, 0);
    end
    check("left_offset_step", offset, 1);
    run_frame(0, 0);
    check("left_row1", got[1], 32'h8000_0000);
    check("left_row0", got[0], 32'h0000_0000);

    // Right scroll wrapping below column 0
    scroll_en = 1'b0;
    run_frame(0, 0);
    scroll_en = 1'b1; dir = 1'b1;
    for (int k = 0; k < 2 * FRAME_DIV; k++) run_frame(0, 0);
    check("wrap_offset", offset, COLS - 1);
    scroll_en = 1'b0;
    run_frame(0, 0);
    check("wrap_row0", got[0], 32'h4000_0000);

    // Interrupted enable clears the frame counter
    scroll_en = 1'b1; dir = 1'b0;
    for (int k = 0; k < 3; k++) run_frame(0, 0);
    scroll_en = 1'b0;
    run_frame(0, 0);
    scroll_en = 1'b1;
    for (int k = 0; k < 3; k++) run_frame(0, 0);
    check("gap_offset_held", offset, COLS - 1);
    run_frame(0, 0);
    check("gap_offset_step", offset, 0);

    // Backpressure on row 3 with a stray frame_start
    scroll_en = 1'b0;
    run_frame(2, 1);
    repeat (10) @(negedge clk);
    check("no_extra_frame", busy, 0);

    // Random scroll settings and random ready
    for (int k = 0; k < 8; k++) begin
      scroll_en = 1'($urandom_range(0, 1));
      dir       = 1'($urandom_range(0, 1));
      run_frame(1, 0);
    end

    // Reset during row 7
    scroll_en = 1'b1; dir = 1'b0;
    @(negedge clk);
    frame_start = 1'b1;
    row_ready   = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    n = 0;
    while (!(row_valid && row_idx == 7) && n < 500) begin
      @(negedge clk);
      n++;
    end
    row_ready = 1'b0;
    check("reach_row7", row_idx, 7);
    @(negedge clk);
    check("row7_held", row_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", row_valid, 0);
    check("midrst_row_data", row_data, 0);
    check("midrst_row_idx", row_idx, 0);
    check("midrst_busy", busy, 0);
    check("midrst_offset", offset, 0);
    check("midrst_rom_addr", rom_addr, 0);
    check("midrst_frame_done", frame_done, 0);
    off_m = 0;
    fc_m  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    row_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_no_done", frame_done, 0);
    check("post_rst_idle", busy, 0);
    scroll_en = 1'b0;
    run_frame(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
